sram_port_arbiter: RTL
======================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter AW, default 8, SRAM address width.
REQ-002 Parameter DW, default 32, SRAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ld_req  input  1  loader burst-read request, level, held until ld_done.
REQ-006 ld_addr  input  AW  loader burst base address, sampled at grant.
REQ-007 ld_len  input  3  loader beats minus one (0..7 = 1..8 beats), sampled at grant.
REQ-008 ld_rvalid  output  1  ld_rdata valid this cycle.
REQ-009 ld_rdata  output  DW  read data to loader.
REQ-010 ld_done  output  1  one-cycle pulse, loader burst finished.
REQ-011 wb_req  input  1  writeback burst-write request, level, held until wb_done.
REQ-012 wb_addr  input  AW  writeback base address, sampled at grant.
REQ-013 wb_len  input  3  writeback beats minus one, sampled at grant.
REQ-014 wb_wdata  input  DW  write data, current beat.
REQ-015 wb_pop  output  1  wb_wdata consumed this cycle; requester advances next cycle.
REQ-016 wb_done  output  1  one-cycle pulse, writeback burst finished.
REQ-017 mem_cen  output  1  SRAM chip enable, active-high.
REQ-018 mem_wen  output  1  SRAM write enable, active-high, only with mem_cen.
REQ-019 mem_addr  output  AW  SRAM address.
REQ-020 mem_wdata  output  DW  SRAM write data.
REQ-021 mem_rdata  input  DW  SRAM read data, valid one cycle after read access.
REQ-022 busy  output  1  high in any state other than IDLE.

Function
REQ-023 FSM states: IDLE, LD_BURST, LD_DRAIN, WB_BURST.
REQ-024 IDLE: if a request is selected (REQ-031), latch its addr/len into base register and beat counter := 0, enter LD_BURST or WB_BURST next cycle.
REQ-025 LD_BURST: each cycle mem_cen=1, mem_wen=0, mem_addr=base+count (AW-bit wrap modulo 2^AW); count increments; on count==len go LD_DRAIN.
REQ-026 Read latency: ld_rvalid asserts exactly one cycle after each LD_BURST access, ld_rdata=mem_rdata; exactly len+1 rvalid pulses per burst.
REQ-027 LD_DRAIN: no SRAM access; last ld_rvalid and ld_done asserted together this cycle; next state IDLE.
REQ-028 WB_BURST: each cycle mem_cen=1, mem_wen=1, mem_addr=base+count (wrap), mem_wdata=wb_wdata, wb_pop=1; on count==len assert wb_done same cycle and go IDLE.
REQ-029 Bursts are non-preemptible; a request arriving mid-burst waits.
REQ-030 Minimum one IDLE cycle between consecutive bursts; mem_cen=0 in IDLE and LD_DRAIN.
REQ-031 Selection in IDLE: only one requester asserted -> that one; both asserted -> per Configuration.
REQ-032 Requester deasserting req before done is a protocol violation; arbiter completes the burst regardless.
REQ-033 len=0: single-beat burst; LD: access cycle then LD_DRAIN; WB: wb_pop and wb_done in same cycle.

Reset
REQ-034 rst high at a rising edge: state=IDLE, counters=0, base=0, priority pointer=loader-first; all outputs 0 the following cycle.
REQ-035 rst mid-burst aborts it; no done pulse, no further rvalid/pop; requester reissues.

Configuration
REQ-036 Macro ARB_RR_EN defined: round-robin; on simultaneous requests grant the requester not served by the most recent burst; pointer updates at each grant.
REQ-037 ARB_RR_EN undefined: fixed priority, loader always wins simultaneous requests; no pointer register.

Verification
REQ-038 ld_req, ld_addr=0x10, ld_len=3 -> mem reads 0x10..0x13 on 4 consecutive cycles, 4 ld_rvalid one cycle later, ld_done with 4th rvalid.
REQ-039 wb_req, wb_addr=0xFE, wb_len=2 -> writes to 0xFE, 0xFF, 0x00 (wrap), 3 wb_pop, wb_done on 3rd write.
REQ-040 ld_req and wb_req held together, two bursts each -> RR: LD, WB, LD, WB; fixed: LD, LD, WB, WB.
REQ-041 wb_req rises during an LD burst (len=7) -> WB grant only after ld_done plus one IDLE cycle.
REQ-042 rst asserted on 3rd beat of WB burst len=5 -> next cycle mem_cen=0, busy=0, no wb_done.
REQ-043 ld_len=0 and wb_len=0 back-to-back -> one access each, done pulses correct, one IDLE cycle between.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM between a burst-read loader and a burst-write writeback port.
// Define ARB_RR_EN for round-robin on simultaneous requests; default is loader-first fixed priority.
module sram_port_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [2:0]    ld_len,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_done,
  input  logic          wb_req,
  input  logic [AW-1:0] wb_addr,
  input  logic [2:0]    wb_len,
  input  logic [DW-1:0] wb_wdata,
  output logic          wb_pop,
  output logic          wb_done,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StLdBurst, StLdDrain, StWbBurst} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [2:0]    len_q, len_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          grant_ld, grant_wb;
  logic          cen_q, cen_d, wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rvalid_q, rvalid_d, ld_done_q, ld_done_d;
  logic          pop_q, pop_d, wb_done_q, wb_done_d, busy_q, busy_d;
`ifdef ARB_RR_EN
  logic          rr_q, rr_d;  // 1: writeback preferred on the next tie
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    grant_ld = 1'b0;
    grant_wb = 1'b0;
`ifdef ARB_RR_EN
    rr_d     = rr_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef ARB_RR_EN
        grant_ld = ld_req && (!wb_req || !rr_q);
`else
        grant_ld = ld_req;
`endif
        grant_wb = wb_req && !grant_ld;
        if (grant_ld) begin
          state_d = StLdBurst;
          base_d  = ld_addr;
          len_d   = ld_len;
          cnt_d   = 3'd0;
`ifdef ARB_RR_EN
          rr_d    = 1'b1;
`endif
        end else if (grant_wb) begin
          state_d = StWbBurst;
          base_d  = wb_addr;
          len_d   = wb_len;
          cnt_d   = 3'd0;
`ifdef ARB_RR_EN
          rr_d    = 1'b0;
`endif
        end
      end
      StLdBurst: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == len_q) state_d = StLdDrain;
      end
      StLdDrain: state_d = StIdle;
      StWbBurst: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == len_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered: decode what the next cycle will present.
  always_comb begin
    cen_d     = (state_d == StLdBurst) || (state_d == StWbBurst);
    wen_d     = (state_d == StWbBurst);
    addr_d    = cen_d ? base_d + AW'(cnt_d) : '0;
    pop_d     = (state_d == StWbBurst);
    wb_done_d = (state_d == StWbBurst) && (cnt_d == len_d);
    rvalid_d  = (state_q == StLdBurst);
    ld_done_d = (state_d == StLdDrain);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      cen_q     <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      rvalid_q  <= 1'b0;
      ld_done_q <= 1'b0;
      pop_q     <= 1'b0;
      wb_done_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ARB_RR_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      cen_q     <= cen_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      rvalid_q  <= rvalid_d;
      ld_done_q <= ld_done_d;
      pop_q     <= pop_d;
      wb_done_q <= wb_done_d;
      busy_q    <= busy_d;
`ifdef ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign mem_cen   = cen_q;
  assign mem_wen   = wen_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wen_q ? wb_wdata : '0;
  assign ld_rvalid = rvalid_q;
  assign ld_rdata  = rvalid_q ? mem_rdata : '0;
  assign ld_done   = ld_done_q;
  assign wb_pop    = pop_q;
  assign wb_done   = wb_done_q;
  assign busy      = busy_q;

endmodule
